// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer for dds_core: latches a sweep configuration over valid/ready
// and drives a registered tuning word through fixed, single, repeat or triangle sweeps.
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [31:0]        cfg_start_freq_i,
  input  logic [31:0]        cfg_stop_freq_i,
  input  logic [31:0]        cfg_step_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic [31:0]        frequency_o,
  output logic               freq_update_o,
  output logic               sweep_done_o,
  output logic               busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_DWELL = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;

  localparam logic [1:0] M_FIXED  = 2'd0;
  localparam logic [1:0] M_REPEAT = 2'd2;
  localparam logic [1:0] M_TRI    = 2'd3;

  logic [2:0]         state_q, state_d;
  logic [31:0]        start_q, start_d;
  logic [31:0]        stop_q, stop_d;
  logic [31:0]        step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         mode_q, mode_d;
  logic               dir_down_q, dir_down_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [31:0]        freq_q, freq_d;
  logic               upd_q, upd_d;
  logic               done_q, done_d;

  logic [32:0] up_sum_s;
  logic [32:0] dn_diff_s;
  logic        up_clamp_s;
  logic        dn_clamp_s;

  assign cfg_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign frequency_o   = freq_q;
  assign freq_update_o = upd_q;
  assign sweep_done_o  = done_q;

  // 33-bit step arithmetic so carry/borrow out of the tuning word forces a clamp.
  always_comb begin
    up_sum_s   = {1'b0, freq_q} + {1'b0, step_q};
    dn_diff_s  = {1'b0, freq_q} - {1'b0, step_q};
    up_clamp_s = up_sum_s[32] | (up_sum_s[31:0] >= stop_q);
    dn_clamp_s = dn_diff_s[32] | (dn_diff_s[31:0] <= start_q);
  end

  // Next-state logic for the sequencer and its config registers.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    stop_d     = stop_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    mode_d     = mode_q;
    dir_down_d = dir_down_q;
    cnt_d      = cnt_q;
    freq_d     = freq_q;
    upd_d      = 1'b0;
    done_d     = 1'b0;

    if (cfg_valid_i && (state_q == S_IDLE)) begin
      start_d = cfg_start_freq_i;
      stop_d  = cfg_stop_freq_i;
      step_d  = cfg_step_i;
      dwell_d = cfg_dwell_i;
      mode_d  = cfg_mode_i;
    end else begin
      mode_d = mode_q;
    end

    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          freq_d     = start_q;
          dir_down_d = 1'b0;
          cnt_d      = dwell_q;
          upd_d      = 1'b1;
          if ((mode_q == M_FIXED) || (step_q == 32'd0) || (start_q >= stop_q)) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_DWELL;
          end
        end
        S_HOLD: begin
          state_d = S_HOLD;
        end
        S_DWELL: begin
          if (cnt_q == {DWELL_W{1'b0}}) begin
            state_d = S_STEP;
          end else begin
            cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
          end
        end
        S_STEP: begin
          cnt_d   = dwell_q;
          upd_d   = 1'b1;
          state_d = S_DWELL;
          case (mode_q)
            M_REPEAT: begin
              // The step after stop was shown restarts the ramp.
              if (freq_q == stop_q) begin
                freq_d = start_q;
                done_d = 1'b1;
              end else if (up_clamp_s) begin
                freq_d = stop_q;
              end else begin
                freq_d = up_sum_s[31:0];
              end
            end
            M_TRI: begin
              if (!dir_down_q) begin
                if (up_clamp_s) begin
                  freq_d     = stop_q;
                  dir_down_d = 1'b1;
                end else begin
                  freq_d = up_sum_s[31:0];
                end
              end else begin
                if (dn_clamp_s) begin
                  freq_d     = start_q;
                  dir_down_d = 1'b0;
                  done_d     = 1'b1;
                end else begin
                  freq_d = dn_diff_s[31:0];
                end
              end
            end
            default: begin
              if (up_clamp_s) begin
                freq_d  = stop_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                freq_d = up_sum_s[31:0];
              end
            end
          endcase
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, config and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      start_q    <= 32'd0;
      stop_q     <= 32'd0;
      step_q     <= 32'd0;
      dwell_q    <= {DWELL_W{1'b0}};
      mode_q     <= 2'd0;
      dir_down_q <= 1'b0;
      cnt_q      <= {DWELL_W{1'b0}};
      freq_q     <= 32'd0;
      upd_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      mode_q     <= mode_d;
      dir_down_q <= dir_down_d;
      cnt_q      <= cnt_d;
      freq_q     <= freq_d;
      upd_q      <= upd_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: a scoreboard of expected tuning-word updates
// (value, done flag, cycle of arrival) checked by a monitor on every freq_update_o pulse.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_start = 32'd0;
  logic [31:0] cfg_stop = 32'd0;
  logic [31:0] cfg_step = 32'd0;
  logic [15:0] cfg_dwell = 16'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] frequency;
  logic        freq_update;
  logic        sweep_done;
  logic        busy;

  typedef struct {
    logic [31:0] f;
    logic        d;
    int          at;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  dds_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_start_freq_i(cfg_start), .cfg_stop_freq_i(cfg_stop),
    .cfg_step_i(cfg_step), .cfg_dwell_i(cfg_dwell), .cfg_mode_i(cfg_mode),
    .start_i(start), .stop_i(stop),
    .frequency_o(frequency), .freq_update_o(freq_update),
    .sweep_done_o(sweep_done), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every update pulse must match the head of the scoreboard, done never stray.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (freq_update) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_update got freq=%h done=%b cyc=%0d", frequency, sweep_done, cyc);
        end else begin
          e = sb.pop_front();
          if (frequency !== e.f || sweep_done !== e.d || cyc !== e.at) begin
            bad++;
            $display("FAIL update got freq=%h done=%b cyc=%0d want freq=%h done=%b cyc=%0d",
                     frequency, sweep_done, cyc, e.f, e.d, e.at);
          end
        end
      end else if (sweep_done) begin
        total++;
        bad++;
        $display("FAIL stray_done got done=1 without update at cyc=%0d want 0", cyc);
      end
    end
  end

  function automatic void push(input logic [31:0] f, input logic d, input int at);
    exp_t e;
    e.f = f; e.d = d; e.at = at;
    sb.push_back(e);
  endfunction

  task automatic cfg_write(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                           input logic [15:0] d, input logic [1:0] m);
    @(posedge clk); #1;
    cfg_start = s; cfg_stop = p; cfg_step = st; cfg_dwell = d; cfg_mode = m;
    cfg_valid = 1'b1;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL cfg_ready_idle got %b want 1", cfg_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic start_pulse(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start got %b want 1", busy);
    end
  endtask

  task automatic stop_pulse(input logic [31:0] held);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || frequency !== held) begin
      bad++;
      $display("FAIL stop_idle got busy=%b freq=%h want busy=0 freq=%h", busy, frequency, held);
    end
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got %0d pending want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (cfg_ready !== 1'b1 || frequency !== 32'd0 || busy !== 1'b0 ||
          freq_update !== 1'b0 || sweep_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_state got rdy=%b f=%h busy=%b upd=%b done=%b want 1 0 0 0 0",
                 cfg_ready, frequency, busy, freq_update, sweep_done);
      end
    end
  endtask

  task automatic test_fixed();
    int t0;
    cfg_write(32'h1000_0000, 32'h2000_0000, 32'd1, 16'd5, 2'd0);
    start_pulse(t0);
    push(32'h1000_0000, 1'b0, t0 + 1);
    wait_empty(10, "fixed");
    total++;
    if (busy !== 1'b1 || frequency !== 32'h1000_0000) begin
      bad++;
      $display("FAIL fixed_hold got busy=%b f=%h want 1 10000000", busy, frequency);
    end
    // Master raises a new config while busy and must hold it.
    cfg_start = 32'h2222_0000; cfg_mode = 2'd0; cfg_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (cfg_ready !== 1'b0) begin
        bad++;
        $display("FAIL cfg_ready_busy got %b want 0", cfg_ready);
      end
    end
    #1 stop_pulse(32'h1000_0000);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    start_pulse(t0);
    push(32'h2222_0000, 1'b0, t0 + 1);
    wait_empty(10, "fixed_new_cfg");
    stop_pulse(32'h2222_0000);
  endtask

  task automatic test_single();
    int t0;
    cfg_write(32'd100, 32'd130, 32'd10, 16'd3, 2'd1);
    start_pulse(t0);
    push(32'd100, 1'b0, t0 + 1);
    push(32'd110, 1'b0, t0 + 6);
    push(32'd120, 1'b0, t0 + 11);
    push(32'd130, 1'b1, t0 + 16);
    wait_empty(40, "single");
    total++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || frequency !== 32'd130) begin
      bad++;
      $display("FAIL single_end got busy=%b rdy=%b f=%0d want 0 1 130", busy, cfg_ready, frequency);
    end
  endtask

  task automatic test_clamp();
    int t0;
    cfg_write(32'd100, 32'd125, 32'd10, 16'd0, 2'd1);
    start_pulse(t0);
    push(32'd100, 1'b0, t0 + 1);
    push(32'd110, 1'b0, t0 + 3);
    push(32'd120, 1'b0, t0 + 5);
    push(32'd125, 1'b1, t0 + 7);
    wait_empty(30, "clamp");
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || frequency !== 32'd125) begin
      bad++;
      $display("FAIL clamp_end got busy=%b f=%0d want 0 125", busy, frequency);
    end
  endtask

  task automatic test_triangle();
    int t0;
    logic [31:0] seq [0:6];
    seq[0] = 32'd0;  seq[1] = 32'd10; seq[2] = 32'd20; seq[3] = 32'd10;
    seq[4] = 32'd0;  seq[5] = 32'd10; seq[6] = 32'd20;
    cfg_write(32'd0, 32'd20, 32'd10, 16'd0, 2'd3);
    start_pulse(t0);
    for (int i = 0; i < 7; i++) push(seq[i], (i == 4), t0 + 1 + 2 * i);
    push(32'd10, 1'b0, t0 + 15);
    wait_empty(40, "triangle");
    stop_pulse(32'd10);
    repeat (6) @(negedge clk);
    total++;
    if (frequency !== 32'd10 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tri_held got f=%0d busy=%b want 10 0", frequency, busy);
    end
    // Restart, then hit asynchronous reset mid-sweep.
    start_pulse(t0);
    push(32'd0, 1'b0, t0 + 1);
    push(32'd10, 1'b0, t0 + 3);
    wait_empty(10, "tri_restart");
    rst_n = 1'b0;
    #1;
    total++;
    if (frequency !== 32'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
        freq_update !== 1'b0 || sweep_done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got f=%h busy=%b rdy=%b upd=%b done=%b want 0 0 1 0 0",
               frequency, busy, cfg_ready, freq_update, sweep_done);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_repeat_overflow();
    int t0;
    cfg_write(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_0200, 16'd1, 2'd2);
    start_pulse(t0);
    push(32'hFFFF_FF00, 1'b0, t0 + 1);
    push(32'hFFFF_FFFF, 1'b0, t0 + 4);
    push(32'hFFFF_FF00, 1'b1, t0 + 7);
    push(32'hFFFF_FFFF, 1'b0, t0 + 10);
    wait_empty(30, "repeat");
    stop_pulse(32'hFFFF_FFFF);
  endtask

  task automatic test_start_ge_stop();
    int t0;
    cfg_write(32'h0000_0500, 32'h0000_0500, 32'd1, 16'd0, 2'd2);
    start_pulse(t0);
    push(32'h0000_0500, 1'b0, t0 + 1);
    wait_empty(10, "hold");
    repeat (20) @(negedge clk);
    total++;
    if (busy !== 1'b1 || frequency !== 32'h0000_0500) begin
      bad++;
      $display("FAIL hold_static got busy=%b f=%h want 1 00000500", busy, frequency);
    end
    #1 stop_pulse(32'h0000_0500);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_single();
    test_clamp();
    test_triangle();
    test_repeat_overflow();
    test_start_ge_stop();
    repeat (4) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
